// File: rtl/game_pixel_gen_if.sv
// Pixel bus between the VGA timing controller and the game pixel source.
//   vga_xide  10  active-area x coordinate (0 outside the active area)
//   vga_yide  10  active-area y coordinate (0 outside the active area)
//   vga_vs     1  vertical sync, active low
//   vga_data   8  RGB332 pixel returned one clock after the coordinates
// master: the timing controller side; slave: the pixel source side.
interface game_pixel_gen_if;
  logic [9:0] vga_xide;
  logic [9:0] vga_yide;
  logic       vga_vs;
  logic [7:0] vga_data;

  modport master (output vga_xide, output vga_yide, output vga_vs, input vga_data);
  modport slave  (input vga_xide, input vga_yide, input vga_vs, output vga_data);
endinterface

// File: rtl/game_pixel_gen.sv
// Ball-and-paddle game engine and RGB332 pixel source for an 800x600 frame.
// Game state advances once per frame on the falling edge of vertical sync;
// the pixel for each coordinate pair is returned one clock later.
// Ports:
//   clk_40mhz   pixel clock
//   rst_n       asynchronous active-low reset
//   vga         pixel bus (slave): coordinates and vsync in, vga_data out
//   btn_left    move paddle left (async level)
//   btn_right   move paddle right (async level)
//   btn_start   start / acknowledge (async, rising edge)
//   score       paddle hits this game, saturating
//   lives       remaining lives
//   game_state  0=IDLE 1=PLAY 2=MISS 3=OVER
//
// state | meaning
// IDLE  | ball parked at centre, paddle movable, waiting for start
// PLAY  | ball and paddle advance every frame
// MISS  | ball went past the paddle; hold for MISS_FRAMES frames
// OVER  | no lives left; start returns to IDLE
module game_pixel_gen #(
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 4,
  parameter int PADDLE_W     = 100,
  parameter int PADDLE_Y     = 570,
  parameter int PADDLE_SPEED = 8,
  parameter int LIVES        = 3,
  parameter int MISS_FRAMES  = 60
) (
  input  logic                    clk_40mhz,
  input  logic                    rst_n,
  game_pixel_gen_if.slave         vga,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_start,
  output logic [7:0]              score,
  output logic [1:0]              lives,
  output logic [1:0]              game_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_MISS = 2'd2, S_OVER = 2'd3} state_t;

  localparam logic [10:0] L_BALL  = 11'(BALL_SIZE);
  localparam logic [10:0] L_SPD   = 11'(BALL_SPEED);
  localparam logic [10:0] L_PW    = 11'(PADDLE_W);
  localparam logic [10:0] L_PY    = 11'(PADDLE_Y);
  localparam logic [10:0] L_PH    = 11'd10;
  localparam logic [10:0] L_PSPD  = 11'(PADDLE_SPEED);
  localparam logic [10:0] L_XMAX  = 11'(800 - BALL_SIZE);
  localparam logic [10:0] L_PMAX  = 11'(800 - PADDLE_W);
  localparam logic [10:0] L_YEND  = 11'd600;
  localparam logic [10:0] L_BX0   = 11'd396;
  localparam logic [10:0] L_BY0   = 11'd296;
  localparam logic [10:0] L_PAD0  = 11'd350;
  localparam logic [1:0]  L_LIVES = 2'(LIVES);
  localparam logic [7:0]  L_MLAST = 8'(MISS_FRAMES - 1);

  state_t      r_state, w_state_nxt;
  logic [10:0] r_ball_x, r_ball_y, r_pad_x;
  logic        r_dir_right, r_dir_down;
  logic [7:0]  r_score, r_miss_cnt, r_data;
  logic [1:0]  r_lives;
  logic        r_left_s1, r_left_s2, r_right_s1, r_right_s2;
  logic        r_start_s1, r_start_s2, r_start_d;
  logic        r_vs_d1, r_vs_d2;

  logic        w_tick, w_start_edge;
  logic [10:0] w_x, w_y, w_bot, w_pad_nxt, w_bx_nxt, w_by_nxt;
  logic        w_dr_nxt, w_dd_nxt, w_hit, w_miss, w_x_ovl, w_miss_done;
  logic        w_launch, w_park, w_play_step, w_miss_step, w_pad_en;
  logic        w_ball_px, w_pad_px;
  logic [7:0]  w_bg;

  // Buttons are asynchronous; vsync is already in this clock domain and
  // only needs a delay line for the edge detect.
  always_ff @(posedge clk_40mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_left_s1  <= 1'b0;
      r_left_s2  <= 1'b0;
      r_right_s1 <= 1'b0;
      r_right_s2 <= 1'b0;
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
      r_vs_d1    <= 1'b0;
      r_vs_d2    <= 1'b0;
    end else begin
      r_left_s1  <= btn_left;
      r_left_s2  <= r_left_s1;
      r_right_s1 <= btn_right;
      r_right_s2 <= r_right_s1;
      r_start_s1 <= btn_start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
      r_vs_d1    <= vga.vga_vs;
      r_vs_d2    <= r_vs_d1;
    end
  end

  assign w_tick       = r_vs_d2 & ~r_vs_d1;
  assign w_start_edge = r_start_s2 & ~r_start_d;
  assign w_x          = {1'b0, vga.vga_xide};
  assign w_y          = {1'b0, vga.vga_yide};
  assign w_bot        = r_ball_y + L_BALL;
  assign w_x_ovl      = (r_ball_x + L_BALL > r_pad_x) && (r_ball_x < r_pad_x + L_PW);
  assign w_miss_done  = (r_miss_cnt == L_MLAST);

  // Pressing both buttons cancels out.
  always_comb begin
    w_pad_nxt = r_pad_x;
    if (r_left_s2 && !r_right_s2) begin
      w_pad_nxt = (r_pad_x < L_PSPD) ? 11'd0 : r_pad_x - L_PSPD;
    end else if (r_right_s2 && !r_left_s2) begin
      w_pad_nxt = (r_pad_x + L_PSPD > L_PMAX) ? L_PMAX : r_pad_x + L_PSPD;
    end
  end

  // One frame of ball motion, from pre-update ball and paddle positions.
  always_comb begin
    w_bx_nxt = r_ball_x;
    w_dr_nxt = r_dir_right;
    w_by_nxt = r_ball_y;
    w_dd_nxt = r_dir_down;
    w_hit    = 1'b0;
    w_miss   = 1'b0;
    if (r_dir_right) begin
      if (r_ball_x + L_SPD > L_XMAX) begin
        w_bx_nxt = L_XMAX;
        w_dr_nxt = 1'b0;
      end else begin
        w_bx_nxt = r_ball_x + L_SPD;
      end
    end else if (r_ball_x < L_SPD) begin
      w_bx_nxt = 11'd0;
      w_dr_nxt = 1'b1;
    end else begin
      w_bx_nxt = r_ball_x - L_SPD;
    end
    if (!r_dir_down) begin
      if (r_ball_y < L_SPD) begin
        w_by_nxt = 11'd0;
        w_dd_nxt = 1'b1;
      end else begin
        w_by_nxt = r_ball_y - L_SPD;
      end
    end else if (w_bot <= L_PY && w_bot + L_SPD >= L_PY && w_x_ovl) begin
      w_by_nxt = L_PY - L_BALL;
      w_dd_nxt = 1'b0;
      w_hit    = 1'b1;
    end else if (w_bot + L_SPD >= L_YEND) begin
      w_miss = 1'b1;
    end else begin
      w_by_nxt = r_ball_y + L_SPD;
    end
  end

  always_ff @(posedge clk_40mhz or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_edge) w_state_nxt = S_PLAY;
      S_PLAY:  if (w_tick && w_miss) w_state_nxt = S_MISS;
      S_MISS:  if (w_tick && w_miss_done) w_state_nxt = (r_lives == 2'd1) ? S_OVER : S_PLAY;
      S_OVER:  if (w_start_edge) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_launch    = 1'b0;
    w_park      = 1'b0;
    w_play_step = 1'b0;
    w_miss_step = 1'b0;
    w_pad_en    = 1'b0;
    w_bg        = 8'h00;
    case (r_state)
      S_IDLE: begin
        w_launch = w_start_edge;
        w_pad_en = w_tick;
      end
      S_PLAY: begin
        w_play_step = w_tick;
        w_pad_en    = w_tick;
      end
      S_MISS: begin
        w_miss_step = w_tick;
        w_bg        = 8'h60;
      end
      S_OVER: begin
        w_park = w_start_edge;
        w_bg   = 8'hE0;
      end
      default: w_bg = 8'h00;
    endcase
  end

  always_ff @(posedge clk_40mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_ball_x    <= L_BX0;
      r_ball_y    <= L_BY0;
      r_dir_right <= 1'b1;
      r_dir_down  <= 1'b0;
      r_pad_x     <= L_PAD0;
      r_score     <= 8'd0;
      r_lives     <= L_LIVES;
      r_miss_cnt  <= 8'd0;
    end else begin
      if (w_pad_en) r_pad_x <= w_pad_nxt;
      if (w_launch) begin
        r_score     <= 8'd0;
        r_lives     <= L_LIVES;
        r_ball_x    <= L_BX0;
        r_ball_y    <= L_BY0;
        r_dir_right <= 1'b1;
        r_dir_down  <= 1'b0;
      end
      if (w_park) begin
        r_ball_x <= L_BX0;
        r_ball_y <= L_BY0;
      end
      if (w_play_step) begin
        // On a miss the ball freezes where it was so the miss is visible.
        if (w_miss) begin
          r_miss_cnt <= 8'd0;
        end else begin
          r_ball_x    <= w_bx_nxt;
          r_ball_y    <= w_by_nxt;
          r_dir_right <= w_dr_nxt;
          r_dir_down  <= w_dd_nxt;
          if (w_hit && r_score != 8'hFF) r_score <= r_score + 8'd1;
        end
      end
      if (w_miss_step) begin
        if (w_miss_done) begin
          r_miss_cnt <= 8'd0;
          r_lives    <= r_lives - 2'd1;
          if (r_lives != 2'd1) begin
            r_ball_x    <= L_BX0;
            r_ball_y    <= L_BY0;
            r_dir_right <= 1'b1;
            r_dir_down  <= 1'b0;
          end
        end else begin
          r_miss_cnt <= r_miss_cnt + 8'd1;
        end
      end
    end
  end

  assign w_ball_px = (w_x >= r_ball_x) && (w_x < r_ball_x + L_BALL) &&
                     (w_y >= r_ball_y) && (w_y < r_ball_y + L_BALL);
  assign w_pad_px  = (w_x >= r_pad_x) && (w_x < r_pad_x + L_PW) &&
                     (w_y >= L_PY) && (w_y < L_PY + L_PH);

  always_ff @(posedge clk_40mhz or negedge rst_n) begin
    if (!rst_n)         r_data <= 8'h00;
    else if (w_ball_px) r_data <= 8'hFF;
    else if (w_pad_px)  r_data <= 8'h1C;
    else                r_data <= w_bg;
  end

  assign vga.vga_data = r_data;
  assign score        = r_score;
  assign lives        = r_lives;
  assign game_state   = r_state;

endmodule

// File: tb/tb_game_pixel_gen.sv
module tb_game_pixel_gen;
  logic       clk_40mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0;
  logic [7:0] score;
  logic [1:0] lives, game_state;

  game_pixel_gen_if vga_if();

  game_pixel_gen dut (
    .clk_40mhz  (clk_40mhz),
    .rst_n      (rst_n),
    .vga        (vga_if),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_start  (btn_start),
    .score      (score),
    .lives      (lives),
    .game_state (game_state)
  );

  always #5 clk_40mhz = ~clk_40mhz;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference game model
  int m_bx, m_by, m_pad, m_score, m_lives, m_state, m_cnt;
  bit m_dr, m_dd;

  typedef struct {
    int         cyc;
    int         x;
    int         y;
    logic [7:0] exp;
  } px_t;
  px_t sb[$];
  px_t mon_e;

  always @(posedge clk_40mhz) cyc <= cyc + 1;

  // Pixel scoreboard: each entry is checked one clock after it was driven.
  always @(negedge clk_40mhz) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      total++;
      if (vga_if.vga_data !== mon_e.exp) begin
        bad++;
        $display("FAIL pixel (%0d,%0d) got %h expected %h", mon_e.x, mon_e.y, vga_if.vga_data, mon_e.exp);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic model_reset;
    m_bx = 396; m_by = 296; m_dr = 1; m_dd = 0; m_pad = 350;
    m_score = 0; m_lives = 3; m_state = 0; m_cnt = 0;
  endtask

  function automatic logic [7:0] model_px(input int x, input int y);
    if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 8'hFF;
    if (x >= m_pad && x < m_pad + 100 && y >= 570 && y < 580) return 8'h1C;
    case (m_state)
      2: return 8'h60;
      3: return 8'hE0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_tick(input bit l, input bit r);
    int npad, nx, ny;
    bit ndr, ndd, hit, miss;
    npad = m_pad;
    if (l && !r) npad = (m_pad < 8) ? 0 : m_pad - 8;
    else if (r && !l) npad = (m_pad + 8 > 700) ? 700 : m_pad + 8;
    case (m_state)
      0: m_pad = npad;
      1: begin
        nx = m_bx; ny = m_by; ndr = m_dr; ndd = m_dd; hit = 0; miss = 0;
        if (m_dr) begin
          if (m_bx + 4 > 792) begin nx = 792; ndr = 0; end else nx = m_bx + 4;
        end else begin
          if (m_bx < 4) begin nx = 0; ndr = 1; end else nx = m_bx - 4;
        end
        if (!m_dd) begin
          if (m_by < 4) begin ny = 0; ndd = 1; end else ny = m_by - 4;
        end else if (m_by + 8 <= 570 && m_by + 12 >= 570 && m_bx + 8 > m_pad && m_bx < m_pad + 100) begin
          ny = 562; ndd = 0; hit = 1;
        end else if (m_by + 12 >= 600) begin
          miss = 1;
        end else begin
          ny = m_by + 4;
        end
        if (miss) begin
          m_state = 2; m_cnt = 0;
        end else begin
          m_bx = nx; m_by = ny; m_dr = ndr; m_dd = ndd;
          if (hit && m_score < 255) m_score++;
        end
        m_pad = npad;
      end
      2: begin
        if (m_cnt == 59) begin
          m_cnt = 0;
          m_lives--;
          if (m_lives == 0) m_state = 3;
          else begin m_state = 1; m_bx = 396; m_by = 296; m_dr = 1; m_dd = 0; end
        end else m_cnt++;
      end
      default: ;
    endcase
  endtask

  task automatic drive_px(input int x, input int y);
    px_t e;
    @(negedge clk_40mhz);
    vga_if.vga_xide = 10'(x);
    vga_if.vga_yide = 10'(y);
    e.cyc = cyc; e.x = x; e.y = y; e.exp = model_px(x, y);
    sb.push_back(e);
  endtask

  task automatic drain;
    repeat (2) @(negedge clk_40mhz);
  endtask

  task automatic probe_scene;
    drive_px(m_bx, m_by);
    drive_px(m_bx + 7, m_by + 7);
    drive_px(m_bx + 8, m_by);
    if (m_bx > 0) drive_px(m_bx - 1, m_by + 3);
    drive_px(m_pad, 575);
    drive_px(m_pad + 99, 579);
    drive_px(0, 0);
    drain();
  endtask

  task automatic frame(input bit l, input bit r);
    @(negedge clk_40mhz);
    btn_left = l; btn_right = r;
    repeat (3) @(negedge clk_40mhz);
    vga_if.vga_vs = 1'b0;
    repeat (2) @(negedge clk_40mhz);
    vga_if.vga_vs = 1'b1;
    model_tick(l, r);
    repeat (2) @(negedge clk_40mhz);
  endtask

  task automatic press_start;
    @(negedge clk_40mhz);
    btn_start = 1'b1;
    repeat (4) @(negedge clk_40mhz);
    btn_start = 1'b0;
    repeat (4) @(negedge clk_40mhz);
    if (m_state == 0) begin
      m_state = 1; m_score = 0; m_lives = 3; m_bx = 396; m_by = 296; m_dr = 1; m_dd = 0;
    end else if (m_state == 3) begin
      m_state = 0; m_bx = 396; m_by = 296;
    end
  endtask

  function automatic bit [1:0] track_btn();
    int pc, bc;
    pc = m_pad + 50; bc = m_bx + 4;
    if (bc > pc + 4) return 2'b01;
    if (bc < pc - 4) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit [1:0] avoid_btn();
    return (m_bx + 4 < 400) ? 2'b01 : 2'b10;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_40mhz);
    model_reset();
    total++;
    if (vga_if.vga_data !== 8'h00 || score !== 8'd0 || lives !== 2'd3 || game_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_hold got data=%h score=%0d lives=%0d state=%0d expected 00/0/3/0",
               vga_if.vga_data, score, lives, game_state);
    end
    rst_n = 1'b1;
    @(negedge clk_40mhz);
    total++;
    if (vga_if.vga_data !== 8'h00 || game_state !== 2'd0) begin
      bad++;
      $display("FAIL reset_release got data=%h state=%0d expected 00/0", vga_if.vga_data, game_state);
    end
    drive_px(400, 300);
    drive_px(395, 300);
    drive_px(403, 303);
    drive_px(404, 303);
    drain();
  endtask

  task automatic test_latency;
    drive_px(350, 575);
    drive_px(0, 0);
    drive_px(449, 579);
    drive_px(450, 579);
    drive_px(350, 580);
    drive_px(349, 570);
    drain();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL latency_queue got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_paddle_clamp;
    for (int i = 0; i < 50; i++) frame(1'b1, 1'b0);
    total++;
    if (game_state !== 2'd0) begin
      bad++; $display("FAIL clamp_state got %0d expected 0", game_state);
    end
    drive_px(0, 575);
    drive_px(99, 579);
    drive_px(100, 575);
    drain();
    frame(1'b1, 1'b1);
    drive_px(0, 575);
    drive_px(100, 575);
    drain();
    for (int i = 0; i < 100; i++) frame(1'b0, 1'b1);
    drive_px(700, 575);
    drive_px(699, 575);
    drive_px(799, 579);
    drive_px(700, 580);
    drain();
  endtask

  task automatic test_play_hits;
    int n;
    bit [1:0] b;
    press_start();
    total++;
    if (game_state !== 2'd1 || score !== 8'd0 || lives !== 2'd3) begin
      bad++;
      $display("FAIL start_play got state=%0d score=%0d lives=%0d expected 1/0/3", game_state, score, lives);
    end
    n = 0;
    while (m_score < 2 && n < 900) begin
      b = track_btn();
      frame(b[1], b[0]);
      total++;
      if (game_state !== 2'(m_state) || score !== 8'(m_score) || lives !== 2'(m_lives)) begin
        bad++;
        $display("FAIL play_status frame=%0d got st=%0d sc=%0d lv=%0d expected st=%0d sc=%0d lv=%0d",
                 n, game_state, score, lives, m_state, m_score, m_lives);
      end
      probe_scene();
      if (n == 20) begin
        press_start();
        total++;
        if (game_state !== 2'd1) begin
          bad++; $display("FAIL start_in_play got %0d expected 1", game_state);
        end
      end
      n++;
    end
    total++;
    if (score !== 8'd2) begin
      bad++; $display("FAIL hit_score got %0d expected 2", score);
    end
  endtask

  task automatic test_miss_over;
    int n, held;
    bit [1:0] b;
    for (int life = 3; life >= 1; life--) begin
      n = 0;
      while (m_state != 2 && n < 1000) begin
        b = avoid_btn();
        frame(b[1], b[0]);
        total++;
        if (game_state !== 2'(m_state) || score !== 8'(m_score) || lives !== 2'(m_lives)) begin
          bad++;
          $display("FAIL avoid_status frame=%0d got st=%0d sc=%0d lv=%0d expected st=%0d sc=%0d lv=%0d",
                   n, game_state, score, lives, m_state, m_score, m_lives);
        end
        probe_scene();
        n++;
      end
      total++;
      if (game_state !== 2'd2) begin
        bad++; $display("FAIL miss_enter life=%0d got state %0d expected 2", life, game_state);
      end
      probe_scene();
      if (life == 3) begin
        press_start();
        total++;
        if (game_state !== 2'd2) begin
          bad++; $display("FAIL start_in_miss got %0d expected 2", game_state);
        end
      end
      for (int i = 0; i < 59; i++) frame(1'b1, 1'b0);
      total++;
      if (game_state !== 2'd2 || lives !== 2'(life)) begin
        bad++;
        $display("FAIL miss_hold life=%0d got state=%0d lives=%0d expected 2/%0d", life, game_state, lives, life);
      end
      frame(1'b0, 1'b0);
      total++;
      if (game_state !== ((life == 1) ? 2'd3 : 2'd1) || lives !== 2'(life - 1)) begin
        bad++;
        $display("FAIL miss_exit life=%0d got state=%0d lives=%0d expected %0d/%0d",
                 life, game_state, lives, (life == 1) ? 3 : 1, life - 1);
      end
      probe_scene();
    end
    held = m_score;
    frame(1'b1, 1'b0);
    total++;
    if (game_state !== 2'd3 || score !== 8'(held)) begin
      bad++; $display("FAIL over_hold got state=%0d score=%0d expected 3/%0d", game_state, score, held);
    end
    probe_scene();
    press_start();
    total++;
    if (game_state !== 2'd0 || score !== 8'(held) || lives !== 2'd0) begin
      bad++;
      $display("FAIL over_to_idle got state=%0d score=%0d lives=%0d expected 0/%0d/0", game_state, score, lives, held);
    end
    drive_px(400, 300);
    drive_px(0, 0);
    drain();
    press_start();
    total++;
    if (game_state !== 2'd1 || score !== 8'd0 || lives !== 2'd3) begin
      bad++;
      $display("FAIL restart got state=%0d score=%0d lives=%0d expected 1/0/3", game_state, score, lives);
    end
  endtask

  task automatic test_reset_midgame;
    bit [1:0] b;
    for (int i = 0; i < 10; i++) begin
      b = track_btn();
      frame(b[1], b[0]);
    end
    probe_scene();
    @(negedge clk_40mhz);
    rst_n = 1'b0;
    #1;
    total++;
    if (vga_if.vga_data !== 8'h00 || score !== 8'd0 || lives !== 2'd3 || game_state !== 2'd0) begin
      bad++;
      $display("FAIL midgame_reset got data=%h score=%0d lives=%0d state=%0d expected 00/0/3/0",
               vga_if.vga_data, score, lives, game_state);
    end
    model_reset();
    repeat (2) @(negedge clk_40mhz);
    rst_n = 1'b1;
    drive_px(400, 300);
    drive_px(350, 575);
    drive_px(349, 575);
    drain();
    frame(1'b0, 1'b1);
    probe_scene();
  endtask

  initial begin
    vga_if.vga_xide = 10'd0;
    vga_if.vga_yide = 10'd0;
    vga_if.vga_vs   = 1'b1;
    model_reset();
    test_reset();
    test_latency();
    test_paddle_clamp();
    test_play_hits();
    test_miss_over();
    test_reset_midgame();
    drain();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_left got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
